neg_share_arbiter: RTL and testbench

Round-robin arbiter that shares one registered negation datapath (eBPF NEG32/NEG64 semantics) among NUM_REQ requesters, such as the per-core ALU issue ports of the eBPF engine in the cl_dram_dma_with_cpu design. Each requester presents an operand with a width-mode bit over a valid/ready handshake. The block grants one requester per cycle, computes the negation into a single-entry result buffer, and returns the result tagged with the requester index over a valid/ready response port.

---
 rtl/hermes_alu_pkg.sv | 16 +
 rtl/negate_datapath.sv | 15 +
 rtl/neg_share_arbiter.sv | 98 +++++++++
 tb/tb_neg_share_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hermes_alu_pkg.sv
// Shared types for the eBPF ALU helpers: operand bundle and result-buffer states.
package hermes_alu_pkg;

  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [63:0] data;
    logic        is64;
  } neg_req_t;

  typedef enum logic [0:0] {
    NB_EMPTY = 1'b0,
    NB_FULL  = 1'b1
  } neg_buf_state_t;

endpackage

// File: rtl/negate_datapath.sv
// eBPF NEG32/NEG64: two's-complement negation, ALU32 results zero-extended.
module negate_datapath (
  input  logic [63:0] a,
  input  logic        is64,
  output logic [63:0] c
);

  logic [31:0] neg32;

  always_comb begin
    neg32 = ~a[31:0] + 32'd1;
    c     = is64 ? (~a + 64'd1) : {32'h0, neg32};
  end

endmodule

// File: rtl/neg_share_arbiter.sv
// Round-robin arbiter sharing one registered negation unit among NUM_REQ requesters,
// with a single-entry result buffer on a valid/ready response port.
module neg_share_arbiter
  import hermes_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_is64,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);

  neg_buf_state_t state_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]   rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;

  neg_req_t        reqs [NUM_REQ];
  neg_req_t        sel_req;
  logic [DW-1:0]   neg_c;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] idx;
  logic            can_accept;
  logic            req_fire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqs[i].data = req_data[DW*i +: DW];
    assign reqs[i].is64 = req_is64[i];
  end

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign can_accept = (state_q == NB_EMPTY) || rsp_ready;
  assign req_fire   = gnt_found && can_accept;
  assign ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_req    = reqs[gnt_idx];

  always_comb begin
    req_ready = '0;
    if (req_fire) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  negate_datapath u_negate_datapath (
    .a    (sel_req.data),
    .is64 (sel_req.is64),
    .c    (neg_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NB_EMPTY;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (req_fire) begin
        rsp_data_q <= neg_c;
        rsp_id_q   <= gnt_idx;
        ptr_q      <= ptr_d;
      end
      case (state_q)
        NB_EMPTY: if (req_fire) state_q <= NB_FULL;
        NB_FULL:  if (rsp_ready && !req_fire) state_q <= NB_EMPTY;
        default:  state_q <= NB_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == NB_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid;

endmodule

// File: tb/tb_neg_share_arbiter.sv
// Directed bench for neg_share_arbiter with a per-cycle reference model and result scoreboard.
module tb_neg_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [63:0]    data;
    logic [IDW-1:0] id;
  } sb_item_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_is64 = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [63:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  sb_item_t        sb [$];
  logic            full_m;
  logic [IDW-1:0]  ptr_m;

  neg_share_arbiter #(
    .NUM_REQ (NREQ),
    .ID_W    (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_is64  (req_is64),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] neg_m(input logic [63:0] a, input logic is64);
    logic [31:0] lo;
    lo = 32'd0 - a[31:0];
    return is64 ? (64'd0 - a) : {32'd0, lo};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] d, input logic is64);
    req_data[64*i +: 64] = d;
    req_is64[i]          = is64;
  endtask

  // Reference model evaluated mid-cycle, when inputs are stable for the coming edge.
  always @(negedge clk) begin
    logic            found;
    logic [IDW-1:0]  g;
    logic            can;
    logic            rfire;
    logic [NREQ-1:0] exp_rdy;
    sb_item_t        it;
    if (rst) begin
      full_m = 1'b0;
      ptr_m  = '0;
      sb.delete();
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end else begin
      found = 1'b0;
      g     = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(int'(ptr_m) + k) % NREQ]) begin
          found = 1'b1;
          g     = IDW'((int'(ptr_m) + k) % NREQ);
        end
      end
      can     = !full_m || rsp_ready;
      exp_rdy = '0;
      if (found && can) exp_rdy[g] = 1'b1;
      check("mdl_req_ready", 64'(req_ready), 64'(exp_rdy));
      check("mdl_rsp_valid", 64'(rsp_valid), 64'(full_m));
      check("mdl_busy", 64'(busy), 64'(full_m));
      rfire = full_m && rsp_ready;
      if (rfire) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          it = sb.pop_front();
          check("sb_rsp_data", rsp_data, it.data);
          check("sb_rsp_id", 64'(rsp_id), 64'(it.id));
        end
      end
      if (found && can) begin
        it.data = neg_m(req_data[64*g +: 64], req_is64[g]);
        it.id   = g;
        sb.push_back(it);
        ptr_m  = IDW'((int'(g) + 1) % NREQ);
        full_m = 1'b1;
      end else if (rfire) begin
        full_m = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset values
    repeat (2) step();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", rsp_data, 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Single requester, NEG64
    rsp_ready = 1'b1;
    set_req(2, 64'h0000_0000_0000_0005, 1'b1);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    #1;
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFB);
    check("single_id", 64'(rsp_id), 64'd2);

    // NEG32 masking and wrap
    set_req(0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #1;
    check("neg32_mask", rsp_data, 64'h0000_0000_FFFF_FFFF);
    check("neg32_mask_id", 64'(rsp_id), 64'd0);
    set_req(0, 64'h0000_0000_8000_0000, 1'b0);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #1;
    check("neg32_wrap", rsp_data, 64'h0000_0000_8000_0000);

    // Grant 3 alone so the pointer returns to 0
    set_req(3, 64'h8000_0000_0000_0000, 1'b1);
    req_valid = 4'b1000;
    step();
    #1;
    check("ptr_wrap_id", 64'(rsp_id), 64'd3);
    check("neg64_min", rsp_data, 64'h8000_0000_0000_0000);

    // Round-robin with all requesters valid
    set_req(0, 64'h0000_0000_0000_0001, 1'b1);
    set_req(1, 64'h0000_0000_0000_0000, 1'b1);
    set_req(2, 64'h1234_5678_9ABC_DEF0, 1'b0);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(rr_exp[c]));
      step();
      check("rr_id", 64'(rsp_id), 64'(c % 4));
    end
    check("neg64_one", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure: result held, no grants
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      step();
    end

    // Drain and refill with requester 1 in the same cycle
    rsp_ready = 1'b1;
    #1;
    check("refill_ready", 64'(req_ready), 64'h2);
    step();
    check("refill_valid", 64'(rsp_valid), 64'd1);
    check("refill_id", 64'(rsp_id), 64'd1);
    check("neg64_zero", rsp_data, 64'd0);
    step();
    check("refill2_id", 64'(rsp_id), 64'd2);

    // Mid-operation reset while FULL with ptr=3
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", rsp_data, 64'd0);
    check("mid_rst_id", 64'(rsp_id), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'h1);
    step();
    check("post_rst_id0", 64'(rsp_id), 64'd0);
    step();
    check("post_rst_id1", 64'(rsp_id), 64'd1);

    // Let everything drain, bounded
    req_valid = '0;
    for (int c = 0; c < 20 && (sb.size() != 0 || rsp_valid); c++) step();
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
